// File: rtl/divisor_restoring_if.sv
// Launch/result bundle for the restoring divider: the controller drives the
// operands and Start, and the divider returns the quotient, remainder and status.
interface divisor_restoring_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] Num;
    logic [WIDTH-1:0] Den;
    logic [WIDTH-1:0] Coc;
    logic [WIDTH-1:0] Res;
    logic             Done;
    logic             Busy;
    logic             DivZero;
    logic             Ovf;

    modport master (output Start, Signed, Num, Den,
                    input  Coc, Res, Done, Busy, DivZero, Ovf);
    modport slave  (input  Start, Signed, Num, Den,
                    output Coc, Res, Done, Busy, DivZero, Ovf);
endinterface

// File: rtl/divisor_restoring.sv
// Iterative shift-subtract divider: one quotient bit per cycle on operand
// magnitudes, with the signs applied in a final fix-up cycle.
module divisor_restoring #(
    parameter int WIDTH = 32
) (
    input logic CLK,
    input logic RSTa,
    divisor_restoring_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] dvd, rem, den;
    logic [WIDTH-1:0] num_mag, den_mag;
    logic [WIDTH-1:0] coc_q, res_q;
    logic [CNT_W-1:0] cnt;
    logic             qsign, rsign, zflag, oflag;
    logic             done_q, busy_q, dz_q, ovf_q;
    logic [WIDTH:0]   shifted, trial;

    assign bus.Coc     = coc_q;
    assign bus.Res     = res_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
    assign bus.DivZero = dz_q;
    assign bus.Ovf     = ovf_q;

    // |MIN| still fits in WIDTH unsigned bits, so no widening is needed
    always_comb begin
        num_mag = (bus.Signed && bus.Num[WIDTH-1]) ? -bus.Num : bus.Num;
        den_mag = (bus.Signed && bus.Den[WIDTH-1]) ? -bus.Den : bus.Den;
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, den};
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.Start) state_nx = (bus.Den == '0) ? FIX : CALC;
            CALC:    if (cnt == CNT_W'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            dvd    <= '0;
            rem    <= '0;
            den    <= '0;
            cnt    <= '0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            zflag  <= 1'b0;
            oflag  <= 1'b0;
            coc_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        busy_q <= 1'b1;
                        rem    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        den    <= den_mag;
                        zflag  <= (bus.Den == '0);
                        oflag  <= bus.Signed && (bus.Num == MIN) && (bus.Den == '1);
                        qsign  <= bus.Signed && (bus.Num[WIDTH-1] ^ bus.Den[WIDTH-1]);
                        rsign  <= bus.Signed && bus.Num[WIDTH-1];
                        // on divide-by-zero the raw dividend is what gets reported
                        dvd    <= (bus.Den == '0) ? bus.Num : num_mag;
                    end
                end
                CALC: begin
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    dz_q   <= zflag;
                    ovf_q  <= oflag;
                    if (zflag) begin
                        coc_q <= '1;
                        res_q <= dvd;
                    end else begin
                        coc_q <= qsign ? -dvd : dvd;
                        res_q <= rsign ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_restoring.sv
// Directed and random checks of the 8-bit divider against a plain-arithmetic
// model, with latency and handshake tracked by a scoreboard.
module tb_divisor_restoring;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RSTa = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    divisor_restoring_if #(.WIDTH(W)) bus();
    divisor_restoring #(.WIDTH(W)) dut (.CLK(CLK), .RSTa(RSTa), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] coc, res;
        logic         dz, ovf;
        int           acc;
    } exp_t;

    typedef struct {
        bit           sg;
        logic [W-1:0] n, d, q, r;
        bit           dz, ov;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[13];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Language division already truncates toward zero with the dividend's sign on %
    function automatic exp_t model(bit sg, logic [W-1:0] n, logic [W-1:0] d);
        exp_t e;
        int   ni, di, q, r;
        e.acc = 0;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (d == 0) begin
            e.coc = '1;
            e.res = n;
            e.dz  = 1'b1;
            return e;
        end
        if (sg) begin
            ni = int'($signed(n));
            di = int'($signed(d));
            e.ovf = (ni == -128 && di == -1);
        end else begin
            ni = int'(n);
            di = int'(d);
        end
        q = ni / di;
        r = ni % di;
        e.coc = q[W-1:0];
        e.res = r[W-1:0];
        return e;
    endfunction

    always @(negedge CLK) begin
        if (RSTa) begin
            chk("done_busy_excl", {31'b0, bus.Done & bus.Busy}, 0);
            if (exp_q.size() != 0 && cyc >= exp_q[0].acc) begin
                exp_t e;
                int   lat;
                e   = exp_q[0];
                lat = e.dz ? 1 : W + 1;
                if (cyc < e.acc + lat) begin
                    chk("busy_during_op", {31'b0, bus.Busy}, 1);
                    chk("early_done", {31'b0, bus.Done}, 0);
                end else begin
                    chk("done_latency", {31'b0, bus.Done}, 1);
                    chk("sb_coc", bus.Coc, e.coc);
                    chk("sb_res", bus.Res, e.res);
                    chk("sb_divzero", {31'b0, bus.DivZero}, {31'b0, e.dz});
                    chk("sb_ovf", {31'b0, bus.Ovf}, {31'b0, e.ovf});
                    void'(exp_q.pop_front());
                end
            end else if (bus.Done) begin
                chk("stray_done", {31'b0, bus.Done}, 0);
            end
        end
    end

    task automatic launch(bit sg, logic [W-1:0] n, logic [W-1:0] d, int acc);
        exp_t e;
        bus.Start  = 1'b1;
        bus.Signed = sg;
        bus.Num    = n;
        bus.Den    = d;
        e = model(sg, n, d);
        e.acc = acc;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge CLK); #1;
            seen = bus.Done;
        end
        chk("done_timeout", {31'b0, seen}, 1);
    endtask

    task automatic do_op(bit sg, logic [W-1:0] n, logic [W-1:0] d);
        launch(sg, n, d, cyc + 1);
        @(posedge CLK); #1;
        bus.Start  = 1'b0;
        bus.Num    = W'($urandom);
        bus.Den    = W'($urandom);
        bus.Signed = 1'($urandom);
        wait_done();
    endtask

    initial begin
        bus.Start = 1'b0; bus.Signed = 1'b0; bus.Num = '0; bus.Den = '0;
        vt[0]  = '{0, 8'd200, 8'd7, 8'h1C, 8'h04, 0, 0};
        vt[1]  = '{1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 0, 0};
        vt[2]  = '{1, 8'h07, 8'hFE, 8'hFD, 8'h01, 0, 0};
        vt[3]  = '{0, 8'hF9, 8'h02, 8'h7C, 8'h01, 0, 0};
        vt[4]  = '{0, 8'h55, 8'h00, 8'hFF, 8'h55, 1, 0};
        vt[5]  = '{1, 8'h55, 8'h00, 8'hFF, 8'h55, 1, 0};
        vt[6]  = '{1, 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1};
        vt[7]  = '{0, 8'h80, 8'hFF, 8'h00, 8'h80, 0, 0};
        vt[8]  = '{0, 8'h05, 8'h09, 8'h00, 8'h05, 0, 0};
        vt[9]  = '{1, 8'hF3, 8'h01, 8'hF3, 8'h00, 0, 0};
        vt[10] = '{0, 8'h64, 8'h0A, 8'h0A, 8'h00, 0, 0};
        vt[11] = '{1, 8'h80, 8'h01, 8'h80, 8'h00, 0, 0};
        vt[12] = '{1, 8'hFB, 8'hFD, 8'h01, 8'hFE, 0, 0};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_coc", bus.Coc, 0);
        chk("rst_res", bus.Res, 0);
        chk("rst_done", {31'b0, bus.Done}, 0);
        chk("rst_busy", {31'b0, bus.Busy}, 0);
        chk("rst_divzero", {31'b0, bus.DivZero}, 0);
        chk("rst_ovf", {31'b0, bus.Ovf}, 0);
        RSTa = 1'b1;
        @(posedge CLK); #1;

        // Directed vectors: pin the model to hand values, then run the DUT
        foreach (vt[i]) begin
            exp_t m;
            m = model(vt[i].sg, vt[i].n, vt[i].d);
            chk($sformatf("model_coc_%0d", i), m.coc, vt[i].q);
            chk($sformatf("model_res_%0d", i), m.res, vt[i].r);
            chk($sformatf("model_flags_%0d", i), {30'b0, m.dz, m.ovf}, {30'b0, vt[i].dz, vt[i].ov});
            do_op(vt[i].sg, vt[i].n, vt[i].d);
            chk($sformatf("lit_coc_%0d", i), bus.Coc, vt[i].q);
            chk($sformatf("lit_res_%0d", i), bus.Res, vt[i].r);
            chk($sformatf("lit_flags_%0d", i), {30'b0, bus.DivZero, bus.Ovf}, {30'b0, vt[i].dz, vt[i].ov});
            @(posedge CLK); #1;
        end

        // Second Start while busy must be ignored
        launch(0, 8'd200, 8'd7, cyc + 1);
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        bus.Start = 1'b1; bus.Num = 8'd3; bus.Den = 8'd1;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        wait_done();
        chk("ignored_start_coc", bus.Coc, 8'h1C);
        chk("ignored_start_res", bus.Res, 8'h04);
        repeat (4) @(posedge CLK);
        #1;

        // Start held high: second op accepted in the IDLE cycle after Done
        begin
            int acc_a;
            acc_a = cyc + 1;
            launch(1, 8'hF9, 8'h02, acc_a);
            @(posedge CLK); #1;
            launch(0, 8'd200, 8'd7, acc_a + W + 2);
            for (int i = 0; i < 40 && cyc < acc_a + W + 2; i++) begin
                @(posedge CLK); #1;
            end
            bus.Start = 1'b0;
            wait_done();
            chk("b2b_coc", bus.Coc, 8'h1C);
        end
        repeat (2) @(posedge CLK);
        #1;

        // Reset mid-operation: outputs clear at once, no Done afterwards
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.Num = 8'd200; bus.Den = 8'd7;
        @(posedge CLK); #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RSTa = 1'b0;
        #1;
        chk("abort_coc", bus.Coc, 0);
        chk("abort_res", bus.Res, 0);
        chk("abort_busy", {31'b0, bus.Busy}, 0);
        chk("abort_done", {31'b0, bus.Done}, 0);
        chk("abort_flags", {30'b0, bus.DivZero, bus.Ovf}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RSTa = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        do_op(0, 8'd100, 8'd10);
        chk("post_rst_coc", bus.Coc, 8'd10);
        chk("post_rst_res", bus.Res, 8'd0);

        // Random sweep, mixing modes and small divisors
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] n, d;
            n = W'($urandom);
            d = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            do_op(1'($urandom), n, d);
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
